axi4_write_fsm: RTL and testbench

Single-port AXI4 write-channel responder (slave) pairing with the existing `axi4_read_fsm`, covering the AW, W and B channels. It accepts one address, then an INCR data burst, then returns a write response. Data goes into an internal word-addressed register file. A side-band debug read port exposes that storage so benches can check written contents without a read channel.

---
 rtl/axi4_write_fsm.sv | 71 +++++++
 tb/tb_axi4_write_fsm.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_write_fsm.sv
// axi4_write_fsm: AXI4 AW/W/B write responder into a word register file; ports: AW (awvalid/awready/awid/awaddr/awlen), W (wvalid/wready/wdata/wstrb/wlast), B (bvalid/bready/bid/bresp), debug read (dbg_addr/dbg_data)
module axi4_write_fsm #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [3:0]        awlen,
  input  logic              wvalid,
  output logic              wready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  output logic              bvalid,
  input  logic              bready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);
  typedef enum logic [1:0] {IDLE, W_DATA, W_RESP} state_t;
  state_t state, state_nx;
  logic [3:0] id_q, len_q, cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic err_q, aw_hs, w_hs, last_beat;
  logic [31:0] mem [DEPTH];
  assign awready   = state == IDLE;
  assign wready    = state == W_DATA;
  assign bvalid    = state == W_RESP;
  assign bid       = id_q;
  assign bresp     = {bvalid & err_q, 1'b0};
  assign dbg_data  = mem[dbg_addr];
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign last_beat = cnt_q == len_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE   ? (aw_hs ? W_DATA : IDLE) :
               state == W_DATA ? (w_hs && last_beat ? W_RESP : W_DATA) :
                                 (bready ? IDLE : W_RESP);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      id_q   <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      addr_q <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (aw_hs) begin
      id_q   <= awid;
      len_q  <= awlen;
      addr_q <= awaddr;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else if (w_hs) begin
      for (int n = 0; n < 4; n++)
        if (wstrb[n]) mem[addr_q][8*n +: 8] <= wdata[8*n +: 8];
      // ADDR_W-bit increment wraps DEPTH-1 -> 0 since DEPTH is a power of two
      addr_q <= addr_q + 1'b1;
      cnt_q  <= cnt_q + 1'b1;
      err_q  <= err_q | (wlast != last_beat);
    end
endmodule

// File: tb/tb_axi4_write_fsm.sv
// tb_axi4_write_fsm: directed stimulus, transaction-level model and per-cycle compare for axi4_write_fsm
module tb_axi4_write_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b1;
  logic [3:0] awid = '0, awlen = '0, wstrb = '0;
  logic [3:0] awaddr = '0, dbg_addr = '0;
  logic [31:0] wdata = '0;
  logic awready, wready, bvalid;
  logic [3:0] bid;
  logic [1:0] bresp;
  logic [31:0] dbg_data;
  int checks = 0, errors = 0;

  axi4_write_fsm #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // transaction-level model: a burst is "awaiting data" with a count of beats left,
  // then "awaiting response acceptance"; memory is a plain array
  logic [31:0] m_mem [16];
  logic m_busy, m_resp, m_err;
  int m_left, m_addr;
  logic [3:0] m_id;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int n = 0; n < 4; n++) if (s[n]) r[8*n +: 8] = d[8*n +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_mem[i] <= '0;
      m_busy <= 1'b0;
      m_resp <= 1'b0;
      m_err  <= 1'b0;
      m_left <= 0;
      m_addr <= 0;
      m_id   <= '0;
    end else if (m_resp) begin
      if (bready) m_resp <= 1'b0;
    end else if (m_busy) begin
      if (wvalid) begin
        m_mem[m_addr] <= merge(m_mem[m_addr], wdata, wstrb);
        m_err  <= m_err | (wlast != (m_left == 1));
        m_addr <= (m_addr + 1) % 16;
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_resp <= 1'b1;
        end
      end
    end else if (awvalid) begin
      m_busy <= 1'b1;
      m_left <= int'(awlen) + 1;
      m_addr <= int'(awaddr);
      m_id   <= awid;
      m_err  <= 1'b0;
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (!rst_n) begin
      chk("rst_wready", {31'b0, wready}, 32'd0);
      chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
    end else begin
      chk("cyc_awready", {31'b0, awready}, {31'b0, !m_busy && !m_resp});
      chk("cyc_wready", {31'b0, wready}, {31'b0, m_busy});
      chk("cyc_bvalid", {31'b0, bvalid}, {31'b0, m_resp});
      if (m_resp) begin
        chk("cyc_bid", {28'b0, bid}, {28'b0, m_id});
        chk("cyc_bresp", {30'b0, bresp}, {30'b0, m_err, 1'b0});
      end
      chk("cyc_dbg", dbg_data, m_mem[dbg_addr]);
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake not seen within bound", name);
  endtask

  task automatic aw(input logic [3:0] id, input logic [3:0] a, input logic [3:0] len);
    awvalid = 1'b1; awid = id; awaddr = a; awlen = len;
    for (int i = 0; i < 20 && !awready; i++) tick();
    if (!awready) timeout("aw_timeout");
    tick();
    awvalid = 1'b0;
  endtask

  task automatic wbeat(input logic [31:0] d, input logic [3:0] s, input logic l);
    wvalid = 1'b1; wdata = d; wstrb = s; wlast = l;
    for (int i = 0; i < 20 && !wready; i++) tick();
    if (!wready) timeout("w_timeout");
    tick();
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic wait_b(output logic [3:0] id, output logic [1:0] resp);
    for (int i = 0; i < 20 && !bvalid; i++) tick();
    if (!bvalid) timeout("b_timeout");
    id = bid;
    resp = bresp;
    tick();
  endtask

  task automatic peek(input logic [3:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk($sformatf("mem[%0d]", a), dbg_data, exp);
  endtask

  logic [3:0] got_id;
  logic [1:0] got_resp;

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_awready", {31'b0, awready}, 32'd1);
    chk("reset_wready", {31'b0, wready}, 32'd0);
    chk("reset_bvalid", {31'b0, bvalid}, 32'd0);
    chk("reset_bid", {28'b0, bid}, 32'd0);
    chk("reset_bresp", {30'b0, bresp}, 32'd0);
    peek(4'd2, 32'h0);

    aw(4'd3, 4'd2, 4'd0);
    chk("single_wready_n1", {31'b0, wready}, 32'd1);
    wbeat(32'hDEAD_BEEF, 4'hF, 1'b1);
    chk("single_bvalid_m1", {31'b0, bvalid}, 32'd1);
    chk("single_bid", {28'b0, bid}, 32'd3);
    chk("single_bresp", {30'b0, bresp}, 32'd0);
    tick();
    chk("single_bvalid_one_cycle", {31'b0, bvalid}, 32'd0);
    chk("single_awready_m2", {31'b0, awready}, 32'd1);
    peek(4'd2, 32'hDEAD_BEEF);

    aw(4'd1, 4'd5, 4'd0);
    wbeat(32'h1111_1111, 4'hF, 1'b1);
    wait_b(got_id, got_resp);
    aw(4'd1, 4'd5, 4'd0);
    wbeat(32'hAAAA_BBBB, 4'b0101, 1'b1);
    wait_b(got_id, got_resp);
    peek(4'd5, 32'h11AA_11BB);

    dbg_addr = 4'd14;
    aw(4'd7, 4'd14, 4'd3);
    wbeat(32'd1, 4'hF, 1'b0);
    wbeat(32'd2, 4'hF, 1'b0);
    tick();
    tick();
    wbeat(32'd3, 4'hF, 1'b0);
    wbeat(32'd4, 4'hF, 1'b1);
    wait_b(got_id, got_resp);
    chk("wrap_bid", {28'b0, got_id}, 32'd7);
    chk("wrap_bresp", {30'b0, got_resp}, 32'd0);
    peek(4'd14, 32'd1);
    peek(4'd15, 32'd2);
    peek(4'd0, 32'd3);
    peek(4'd1, 32'd4);

    bready = 1'b0;
    aw(4'd5, 4'd7, 4'd0);
    wbeat(32'h5555_5555, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("stall_bvalid", {31'b0, bvalid}, 32'd1);
      chk("stall_bid", {28'b0, bid}, 32'd5);
      chk("stall_bresp", {30'b0, bresp}, 32'd0);
      chk("stall_awready", {31'b0, awready}, 32'd0);
      tick();
    end
    bready = 1'b1;
    chk("stall_bvalid_at_release", {31'b0, bvalid}, 32'd1);
    tick();
    chk("stall_awready_after", {31'b0, awready}, 32'd1);
    chk("stall_bvalid_after", {31'b0, bvalid}, 32'd0);
    peek(4'd7, 32'h5555_5555);

    aw(4'd2, 4'd8, 4'd2);
    wbeat(32'hA0, 4'hF, 1'b1);
    wbeat(32'hA1, 4'hF, 1'b0);
    wbeat(32'hA2, 4'hF, 1'b1);
    wait_b(got_id, got_resp);
    chk("early_last_bid", {28'b0, got_id}, 32'd2);
    chk("early_last_bresp", {30'b0, got_resp}, 32'd2);
    peek(4'd8, 32'hA0);
    peek(4'd9, 32'hA1);
    peek(4'd10, 32'hA2);

    aw(4'd4, 4'd11, 4'd1);
    wbeat(32'hB0, 4'hF, 1'b0);
    wbeat(32'hB1, 4'hF, 1'b0);
    wait_b(got_id, got_resp);
    chk("missing_last_bid", {28'b0, got_id}, 32'd4);
    chk("missing_last_bresp", {30'b0, got_resp}, 32'd2);

    aw(4'd6, 4'd12, 4'd0);
    wbeat(32'hC0, 4'hF, 1'b1);
    wait_b(got_id, got_resp);
    chk("clean_after_err_bresp", {30'b0, got_resp}, 32'd0);

    aw(4'd9, 4'd3, 4'd3);
    wbeat(32'hD0, 4'hF, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_wready", {31'b0, wready}, 32'd0);
    chk("abort_bvalid", {31'b0, bvalid}, 32'd0);
    for (int i = 0; i < 16; i++) peek(4'(i), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_awready", {31'b0, awready}, 32'd1);
    aw(4'd3, 4'd2, 4'd0);
    wbeat(32'hDEAD_BEEF, 4'hF, 1'b1);
    wait_b(got_id, got_resp);
    chk("fresh_bid", {28'b0, got_id}, 32'd3);
    chk("fresh_bresp", {30'b0, got_resp}, 32'd0);
    peek(4'd2, 32'hDEAD_BEEF);
    peek(4'd3, 32'h0);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
